// File: rtl/pico_ahb_master.sv
// Bridges a picorv32-style native memory port onto AHB-Lite as single non-pipelined transfers.
// Best-case latency is 3 cycles; slave wait states stretch it, and a stuck slave is aborted after WAIT_TIMEOUT cycles.
module pico_ahb_master #(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic [1:0]  hresp,
  output logic        bus_err
);

  localparam int CW = (WAIT_TIMEOUT > 255) ? $clog2(WAIT_TIMEOUT + 1) : 8;
  localparam logic [CW:0] TMO = (CW + 1)'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t        state_q, state_d;
  logic [31:0]   haddr_q, haddr_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          hwrite_q, hwrite_d;
  logic [2:0]    hsize_q, hsize_d;
  logic [3:0]    hprot_q, hprot_d;
  logic [31:0]   hwdata_q, hwdata_d;
  logic          mem_ready_q, mem_ready_d;
  logic [31:0]   mem_rdata_q, mem_rdata_d;
  logic          bus_err_q, bus_err_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW:0]   wait_inc;

  logic          dec_legal;
  logic          dec_write;
  logic [2:0]    dec_size;
  logic [1:0]    dec_lane;

  // Only naturally aligned byte/half/word strobe patterns map onto an AHB size.
  always_comb begin
    dec_legal = 1'b1;
    dec_write = 1'b1;
    dec_size  = 3'b010;
    dec_lane  = 2'b00;
    case (mem_wstrb)
      4'b0000: dec_write = 1'b0;
      4'b1111: dec_size  = 3'b010;
      4'b0011: dec_size  = 3'b001;
      4'b1100: begin dec_size = 3'b001; dec_lane = 2'b10; end
      4'b0001: dec_size  = 3'b000;
      4'b0010: begin dec_size = 3'b000; dec_lane = 2'b01; end
      4'b0100: begin dec_size = 3'b000; dec_lane = 2'b10; end
      4'b1000: begin dec_size = 3'b000; dec_lane = 2'b11; end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hprot_d     = hprot_q;
    hwdata_d    = hwdata_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    bus_err_d   = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    wait_inc    = {1'b0, wait_cnt_q} + 1'b1;

    case (state_q)
      S_IDLE: begin
        // A request still high during the completion pulse belongs to the finished transfer.
        if (mem_valid && !mem_ready_q) begin
          if (dec_legal) begin
            state_d    = S_ADDR;
            htrans_d   = 2'b10;
            haddr_d    = {mem_addr[31:2], dec_lane};
            hwrite_d   = dec_write;
            hsize_d    = dec_size;
            hprot_d    = mem_instr ? 4'b0010 : 4'b0011;
            hwdata_d   = mem_wdata;
            wait_cnt_d = '0;
          end else begin
            mem_ready_d = 1'b1;
            bus_err_d   = 1'b1;
          end
        end
      end
      S_ADDR, S_DATA: begin
        if (hready) begin
          wait_cnt_d = '0;
          htrans_d   = 2'b00;
          if (state_q == S_ADDR) begin
            state_d = S_DATA;
          end else begin
            state_d     = S_IDLE;
            mem_ready_d = 1'b1;
            if (hresp != 2'b00) begin
              bus_err_d   = 1'b1;
              mem_rdata_d = '0;
            end else if (!hwrite_q) begin
              mem_rdata_d = hrdata;
            end
          end
        end else if (wait_inc >= TMO) begin
          state_d     = S_IDLE;
          htrans_d    = 2'b00;
          mem_ready_d = 1'b1;
          bus_err_d   = 1'b1;
          mem_rdata_d = '0;
          wait_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_inc[CW-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= S_IDLE;
      haddr_q     <= '0;
      htrans_q    <= 2'b00;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b010;
      hprot_q     <= 4'b0011;
      hwdata_q    <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      bus_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hprot_q     <= hprot_d;
      hwdata_q    <= hwdata_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      bus_err_q   <= bus_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hburst    = 3'b000;
  assign hprot     = hprot_q;
  assign hwdata    = hwdata_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_pico_ahb_master.sv
// Bench for pico_ahb_master: a scripted AHB slave plus a completion scoreboard keyed on mem_ready.
module tb_pico_ahb_master;

  localparam int TMO = 4;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata, hrdata;
  logic        hready;
  logic [1:0]  hresp;
  logic        bus_err;

  always #5 hclk = ~hclk;

  pico_ahb_master #(.WAIT_TIMEOUT(TMO)) dut (
    .hclk(hclk), .hreset(hreset),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rdata;
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic run(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wdata, input logic instr, input logic [31:0] rd,
                     input int aw, input int dw, input logic err, input logic legal,
                     input logic [31:0] exp_haddr, input logic [2:0] exp_size, input int exp_lat);
    exp_t e;
    exp_t g;
    int   cyc, nonseq, wa, wd;
    logic in_data, done, fail;
    fail    = !legal || err || (aw >= TMO) || (dw >= TMO);
    e.lat   = exp_lat;
    e.err   = fail;
    e.rdata = !legal ? last_rdata : fail ? 32'h0 : (strb == 4'b0000) ? rd : last_rdata;
    last_rdata = e.rdata;
    sb.push_back(e);

    mem_valid = 1'b1; mem_addr = addr; mem_wstrb = strb; mem_wdata = wdata; mem_instr = instr;
    hready = 1'b1; hresp = 2'b00; hrdata = 32'h5A5A_5A5A;
    cyc = 0; nonseq = 0; wa = 0; wd = 0; in_data = 1'b0; done = 1'b0;
    while (!done && cyc < 40) begin
      tick;
      cyc++;
      if (htrans == 2'b10) nonseq++;
      if (cyc == 1 && legal) begin
        check_eq({tag, "/htrans"}, 32'(htrans), 32'h2);
        check_eq({tag, "/haddr"}, haddr, exp_haddr);
        check_eq({tag, "/hsize"}, 32'(hsize), 32'(exp_size));
        check_eq({tag, "/hwrite"}, 32'(hwrite), 32'(strb != 4'b0000));
        check_eq({tag, "/hprot"}, 32'(hprot), instr ? 32'h2 : 32'h3);
      end
      if (mem_ready) begin
        g = sb.pop_front();
        check_eq({tag, "/lat"}, cyc, g.lat);
        check_eq({tag, "/rdata"}, mem_rdata, g.rdata);
        check_eq({tag, "/err"}, 32'(bus_err), 32'(g.err));
        hready = 1'b1; hresp = 2'b00;
        done = 1'b1;
      end else if (in_data) begin
        check_eq({tag, "/data_htrans"}, 32'(htrans), 32'h0);
        check_eq({tag, "/hwdata"}, hwdata, wdata);
        hresp = err ? 2'b01 : 2'b00;
        if (wd < dw) begin
          hready = 1'b0;
          wd++;
        end else begin
          hready = 1'b1;
          hrdata = rd;
        end
        if (hready) in_data = 1'b0;
      end else if (htrans == 2'b10) begin
        hresp = 2'b00;
        if (wa < aw) begin
          hready = 1'b0;
          wa++;
        end else begin
          hready = 1'b1;
          in_data = 1'b1;
        end
      end
    end
    if (!done) check_eq({tag, "/no_ready"}, cyc, exp_lat);
    if (!legal) check_eq({tag, "/nonseq"}, nonseq, 0);
    // mem_valid stays high across the completion edge; it must not restart a transfer.
    tick;
    mem_valid = 1'b0;
    check_eq({tag, "/pulse"}, 32'(mem_ready), 32'h0);
    check_eq({tag, "/idle_htrans"}, 32'(htrans), 32'h0);
    tick;
  endtask

  initial begin
    hreset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0;
    mem_wstrb = '0; hrdata = '0; hready = 1'b1; hresp = 2'b00;
    last_rdata = 32'h0;
    tick;
    tick;
    check_eq("rst/htrans", 32'(htrans), 32'h0);
    check_eq("rst/haddr", haddr, 32'h0);
    check_eq("rst/hwrite", 32'(hwrite), 32'h0);
    check_eq("rst/hsize", 32'(hsize), 32'h2);
    check_eq("rst/hprot", 32'(hprot), 32'h3);
    check_eq("rst/hburst", 32'(hburst), 32'h0);
    check_eq("rst/hwdata", hwdata, 32'h0);
    check_eq("rst/ready", 32'(mem_ready), 32'h0);
    check_eq("rst/rdata", mem_rdata, 32'h0);
    check_eq("rst/err", 32'(bus_err), 32'h0);
    hreset = 1'b0;
    tick;

    //   tag        addr          strb     wdata          ins   rd            aw  dw  err   legal haddr         size    lat
    run("rd_word",  32'h0000_0100, 4'b0000, 32'h0,         1'b0, 32'hDEADBEEF, 0,  0,  1'b0, 1'b1, 32'h0000_0100, 3'b010, 3);
    run("wr_byte2", 32'h0000_0203, 4'b0100, 32'h00AB_0000, 1'b0, 32'h1111_1111, 0, 0,  1'b0, 1'b1, 32'h0000_0202, 3'b000, 3);
    run("fetch",    32'h0000_1004, 4'b0000, 32'h0,         1'b1, 32'h1234_5678, 0, 0,  1'b0, 1'b1, 32'h0000_1004, 3'b010, 3);
    run("wr_half1", 32'h0000_0401, 4'b1100, 32'hBEEF_0000, 1'b0, 32'h0,        0,  0,  1'b0, 1'b1, 32'h0000_0402, 3'b001, 3);
    run("wr_half0", 32'h0000_0403, 4'b0011, 32'h0000_C0DE, 1'b0, 32'h0,        0,  0,  1'b0, 1'b1, 32'h0000_0400, 3'b001, 3);
    run("wr_byte3", 32'h0000_0010, 4'b1000, 32'h7700_0000, 1'b0, 32'h0,        0,  0,  1'b0, 1'b1, 32'h0000_0013, 3'b000, 3);
    run("wr_byte1", 32'h0000_0020, 4'b0010, 32'h0000_6600, 1'b0, 32'h0,        0,  0,  1'b0, 1'b1, 32'h0000_0021, 3'b000, 3);
    run("wr_aw2",   32'h0000_0500, 4'b1111, 32'h0102_0304, 1'b0, 32'h0,        2,  0,  1'b0, 1'b1, 32'h0000_0500, 3'b010, 5);
    run("rd_dw3",   32'h0000_0604, 4'b0000, 32'h0,         1'b0, 32'hCAFE_F00D, 0, 3,  1'b0, 1'b1, 32'h0000_0604, 3'b010, 6);
    run("rd_error", 32'h0000_0700, 4'b0000, 32'h0,         1'b0, 32'h9999_9999, 0, 1,  1'b1, 1'b1, 32'h0000_0700, 3'b010, 4);
    run("rd_again", 32'h0000_0704, 4'b0000, 32'h0,         1'b0, 32'h0F0F_0F0F, 0, 0,  1'b0, 1'b1, 32'h0000_0704, 3'b010, 3);
    run("timeout",  32'h0000_0800, 4'b0000, 32'h0,         1'b0, 32'h7777_7777, 99, 0, 1'b0, 1'b1, 32'h0000_0800, 3'b010, 5);
    run("rd_post",  32'h0000_0900, 4'b0000, 32'h0,         1'b0, 32'h55AA_33CC, 0, 0,  1'b0, 1'b1, 32'h0000_0900, 3'b010, 3);
    run("illegal",  32'h0000_0A00, 4'b0110, 32'hFFFF_FFFF, 1'b0, 32'h0,        0,  0,  1'b0, 1'b0, 32'h0,         3'b010, 1);

    // Reset while the slave is stalling the data phase.
    mem_valid = 1'b1; mem_addr = 32'h0000_0B00; mem_wstrb = 4'b0000; mem_instr = 1'b0;
    hready = 1'b1; hresp = 2'b00;
    tick;
    check_eq("rstmid/addr_phase", 32'(htrans), 32'h2);
    tick;
    hready = 1'b0; mem_valid = 1'b0; hreset = 1'b1;
    tick;
    hreset = 1'b0; hready = 1'b1;
    check_eq("rstmid/htrans", 32'(htrans), 32'h0);
    check_eq("rstmid/ready", 32'(mem_ready), 32'h0);
    check_eq("rstmid/rdata", mem_rdata, 32'h0);
    check_eq("rstmid/err", 32'(bus_err), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check_eq("rstmid/no_ready", 32'(mem_ready), 32'h0);
    end
    last_rdata = 32'h0;
    run("rd_after_rst", 32'h0000_0C00, 4'b0000, 32'h0, 1'b0, 32'hA5A5_0001, 0, 0, 1'b0, 1'b1, 32'h0000_0C00, 3'b010, 3);

    check_eq("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
